// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the handshaked ALU-control decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Native 4-bit ALU control codes; wider CTRL_W zero-extends these.
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_MULT    = 4'b1000;
  localparam logic [3:0] ALU_DIV     = 4'b1001;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // R-type funct encodings.
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  // alu_op classes from the main control unit.
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_LOGIC = 2'b11;

  // Decoded result bundle carried from the decoder to the result register.
  typedef struct packed {
    logic [3:0] code;
    logic       multi;
    logic       illegal;
  } dec_t;

  // Build a decode result; an illegal request is never treated as multi-cycle.
  function automatic dec_t mk_dec(input logic [3:0] code, input logic multi);
    dec_t d;
    d.code    = code;
    d.multi   = multi;
    d.illegal = 1'b0;
    return d;
  endfunction

  localparam dec_t DEC_ILLEGAL = '{code: ALU_ILLEGAL, multi: 1'b0, illegal: 1'b1};

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational map of {alu_op, funct} to {ALU code, multi, illegal}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing sequencer decides when the result is captured.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 2,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec
);

  // Decode table; anything not listed falls through to the illegal code.
  always_comb begin
    dec = DEC_ILLEGAL;
    case (alu_op)
      OP_W'(OP_ADD):   dec = mk_dec(ALU_ADD, 1'b0);
      OP_W'(OP_SUB):   dec = mk_dec(ALU_SUB, 1'b0);
      OP_W'(OP_LOGIC): dec = mk_dec(ALU_OR,  1'b0);
      OP_W'(OP_RTYPE): begin
        case (funct)
          FUNCT_W'(F_ADD):  dec = mk_dec(ALU_ADD,  1'b0);
          FUNCT_W'(F_SUB):  dec = mk_dec(ALU_SUB,  1'b0);
          FUNCT_W'(F_AND):  dec = mk_dec(ALU_AND,  1'b0);
          FUNCT_W'(F_OR):   dec = mk_dec(ALU_OR,   1'b0);
          FUNCT_W'(F_SLT):  dec = mk_dec(ALU_SLT,  1'b0);
          FUNCT_W'(F_MULT): dec = mk_dec(ALU_MULT, 1'b1);
          FUNCT_W'(F_DIV):  dec = mk_dec(ALU_DIV,  1'b1);
          default:          dec = DEC_ILLEGAL;
        endcase
      end
      default: dec = DEC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU-control sequencer: decodes a request and presents it on a valid/ready output.
// Latency: 1 cycle accept->out_valid for single-cycle/illegal ops, MULTI_LAT cycles for MULT/DIV.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready (optional ALU_CTRL_PERF_EN adds counters).
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W      = 2,
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MULTI_LAT = 4   // must be >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               multi,
`ifdef ALU_CTRL_PERF_EN
  output logic [15:0]        op_count,
  output logic [7:0]         err_count,
`endif
  output logic               illegal
);

  localparam int CNT_W = $clog2(MULTI_LAT);
  // WAIT lasts MULTI_LAT-1 cycles: counter runs MULTI_LAT-2 down to 0, then DONE follows.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 2);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic             fire;
  logic             out_hs;

  alu_ctrl_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .dec    (dec)
  );

  assign fire   = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Next-state and handshake outputs; requests are only looked at in IDLE.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = dec.multi ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Multi-cycle latency counter, loaded on accept of MULT/DIV and drained in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (fire && dec.multi) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Result register: captured only on accept so it stays stable through WAIT and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl <= '0;
      multi    <= 1'b0;
      illegal  <= 1'b0;
    end else if (fire) begin
      alu_ctrl <= CTRL_W'(dec.code);
      multi    <= dec.multi;
      illegal  <= dec.illegal;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  // Saturating counters of completed output handshakes and of illegal ones among them.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (out_hs) begin
      if (op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
      if (illegal && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  // out_hs only feeds the optional counters; keep it referenced in the base build.
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq with a queue of expected results.
// Latency: checks 1-cycle and MULTI_LAT-cycle accept->out_valid.
// Backpressure: exercises out_ready stalls, held in_valid, and reset mid-operation.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] alu_ctrl;
  logic       multi;
  logic       illegal;
`ifdef ALU_CTRL_PERF_EN
  logic [15:0] op_count;
  logic [7:0]  err_count;
`endif

  typedef struct {
    logic [3:0] ctrl;
    logic       mul;
    logic       ill;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_ctrl_seq #(
    .OP_W(2), .FUNCT_W(6), .CTRL_W(4), .MULTI_LAT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .multi     (multi),
`ifdef ALU_CTRL_PERF_EN
    .op_count  (op_count),
    .err_count (err_count),
`endif
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the decode table.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f);
    exp_t e;
    e.ctrl = 4'b1111; e.mul = 1'b0; e.ill = 1'b1; e.lat = 1;
    case (op)
      2'b00: begin e.ctrl = 4'b0010; e.ill = 1'b0; end
      2'b01: begin e.ctrl = 4'b0110; e.ill = 1'b0; end
      2'b11: begin e.ctrl = 4'b0001; e.ill = 1'b0; end
      default: begin
        case (f)
          6'b100000: begin e.ctrl = 4'b0010; e.ill = 1'b0; end
          6'b100010: begin e.ctrl = 4'b0110; e.ill = 1'b0; end
          6'b100100: begin e.ctrl = 4'b0000; e.ill = 1'b0; end
          6'b100101: begin e.ctrl = 4'b0001; e.ill = 1'b0; end
          6'b101010: begin e.ctrl = 4'b0111; e.ill = 1'b0; end
          6'b011000: begin e.ctrl = 4'b1000; e.ill = 1'b0; e.mul = 1'b1; e.lat = 4; end
          6'b011010: begin e.ctrl = 4'b1001; e.ill = 1'b0; e.mul = 1'b1; e.lat = 4; end
          default: ;
        endcase
      end
    endcase
    return e;
  endfunction

  // Drive one request for one accept edge and record what it should produce.
  task automatic issue(input logic [1:0] op, input logic [5:0] f);
    @(negedge clk);
    alu_op = op; funct = f; in_valid = 1'b1;
    sb.push_back(model(op, f));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1; in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011000;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    rst = 1'b0; in_valid = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL reset_hold: out_valid high %0d times, required 0", bad);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_state: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    tests++;
    if ({alu_ctrl, multi, illegal} !== 6'b0) begin
      fails++; $display("FAIL reset_regs: ctrl=%b multi=%b illegal=%b, required 0", alu_ctrl, multi, illegal);
    end
`ifdef ALU_CTRL_PERF_EN
    tests++;
    if (op_count !== 16'd0 || err_count !== 8'd0) begin
      fails++; $display("FAIL reset_perf: op=%0d err=%0d, required 0/0", op_count, err_count);
    end
`endif
  endtask

  task automatic test_decode();
    logic [1:0] ops [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] fns [8] = '{6'b000000, 6'b111111, 6'b010101, 6'b100000,
                            6'b100010, 6'b100100, 6'b100101, 6'b101010};
    exp_t e;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], fns[i]);
      wait_valid(n);
      e = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || n !== e.lat) begin
        fails++; $display("FAIL decode_lat[%0d]: %0d cycles, required %0d", i, n, e.lat);
      end
      tests++;
      if ({alu_ctrl, multi, illegal} !== {e.ctrl, e.mul, e.ill}) begin
        fails++; $display("FAIL decode_val[%0d]: ctrl=%b multi=%b ill=%b, required %b/%b/%b",
                          i, alu_ctrl, multi, illegal, e.ctrl, e.mul, e.ill);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++; $display("FAIL decode_idle[%0d]: in_ready=%b out_valid=%b, required 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_multi();
    logic [5:0] fns [2] = '{6'b011000, 6'b011010};
    exp_t e;
    int n;
    int rdy_bad;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(2'b10, fns[i]);
      // Hold a different request on the input; it must be ignored while busy.
      in_valid = 1'b1; alu_op = 2'b00;
      n = 0; rdy_bad = 0;
      do begin
        @(negedge clk);
        n++;
        if (in_ready !== 1'b0) rdy_bad++;
      end while (!out_valid && n < 40);
      in_valid = 1'b0;
      e = sb.pop_front();
      tests++;
      if (n !== e.lat || rdy_bad !== 0) begin
        fails++; $display("FAIL multi_lat[%0d]: %0d cycles in_ready_hi=%0d, required %0d/0", i, n, rdy_bad, e.lat);
      end
      tests++;
      if ({alu_ctrl, multi, illegal} !== {e.ctrl, e.mul, e.ill}) begin
        fails++; $display("FAIL multi_val[%0d]: ctrl=%b multi=%b ill=%b, required %b/%b/%b",
                          i, alu_ctrl, multi, illegal, e.ctrl, e.mul, e.ill);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++; $display("FAIL multi_idle[%0d]: in_ready=%b out_valid=%b, required 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int n;
`ifdef ALU_CTRL_PERF_EN
    logic [7:0]  err0;
    logic [15:0] op0;
    err0 = err_count; op0 = op_count;
`endif
    out_ready = 1'b1;
    issue(2'b10, 6'b111111);
    wait_valid(n);
    e = sb.pop_front();
    tests++;
    if (n !== 1 || {alu_ctrl, multi, illegal} !== {e.ctrl, e.mul, e.ill}) begin
      fails++; $display("FAIL illegal: lat=%0d ctrl=%b multi=%b ill=%b, required 1/%b/%b/%b",
                        n, alu_ctrl, multi, illegal, e.ctrl, e.mul, e.ill);
    end
    @(negedge clk);
`ifdef ALU_CTRL_PERF_EN
    tests++;
    if (err_count !== err0 + 8'd1 || op_count !== op0 + 16'd1) begin
      fails++; $display("FAIL illegal_perf: err=%0d op=%0d, required %0d/%0d", err_count, op_count, err0 + 8'd1, op0 + 16'd1);
    end
`endif
    // A funct that is close to DIV but undefined must still be single-cycle, not multi.
    issue(2'b10, 6'b011011);
    wait_valid(n);
    e = sb.pop_front();
    tests++;
    if (n !== 1 || multi !== 1'b0 || illegal !== 1'b1 || alu_ctrl !== e.ctrl) begin
      fails++; $display("FAIL illegal_near_div: lat=%0d ctrl=%b multi=%b ill=%b, required 1/1111/0/1", n, alu_ctrl, multi, illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    exp_t e;
    int n;
    int bad;
    out_ready = 1'b0;
    issue(2'b01, 6'b100100);
    wait_valid(n);
    e = sb.pop_front();
    bad = 0;
    repeat (5) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_ctrl !== e.ctrl) bad++;
      @(negedge clk);
    end
    tests++;
    if (n !== 1 || bad !== 0) begin
      fails++; $display("FAIL hold_stable: lat=%0d unstable=%0d ctrl=%b, required 1/0/%b", n, bad, alu_ctrl, e.ctrl);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n;
    int seen;
    out_ready = 1'b1;
    seen = 0;
    issue(2'b10, 6'b011010);
    repeat (2) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_idle: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    rst = 1'b0;
    void'(sb.pop_front());
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL rst_mid_discard: out_valid seen %0d times, required 0", seen);
    end
    issue(2'b00, 6'b011010);
    wait_valid(n);
    e = sb.pop_front();
    tests++;
    if (n !== 1 || {alu_ctrl, multi, illegal} !== {e.ctrl, e.mul, e.ill}) begin
      fails++; $display("FAIL rst_mid_add: lat=%0d ctrl=%b multi=%b ill=%b, required 1/%b/%b/%b",
                        n, alu_ctrl, multi, illegal, e.ctrl, e.mul, e.ill);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int fires;
    int outs;
    int overlap;
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] op0;
    op0 = op_count;
`endif
    fires = 0; outs = 0; overlap = 0;
    out_ready = 1'b1;
    @(negedge clk);
    alu_op = 2'b00; in_valid = 1'b1;
    repeat (12) begin
      if (in_ready === 1'b1) fires++;
      if (out_valid === 1'b1) outs++;
      if (in_ready === 1'b1 && out_valid === 1'b1) overlap++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (fires !== 6 || outs !== 6 || overlap !== 0) begin
      fails++; $display("FAIL b2b: fires=%0d outs=%0d overlap=%0d, required 6/6/0", fires, outs, overlap);
    end
    @(negedge clk);
`ifdef ALU_CTRL_PERF_EN
    tests++;
    if (op_count !== op0 + 16'd6) begin
      fails++; $display("FAIL b2b_perf: op=%0d, required %0d", op_count, op0 + 16'd6);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_multi();
    test_illegal();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    tests++;
    if (sb.size() !== 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
